flash_word_reader: RTL and testbench
====================================

Name: flash_word_reader

Overview:
SPI flash read engine (mode 0, command 0x03) that streams 32-bit little-endian words out of an external SPI flash through a valid/ready handshake. It sits directly upstream of the boot-copy logic that writes words into RAMIO. It owns the flash pins, the power-up wait, and command/address sequencing, so the consumer only sees words.

Parameters:
STARTUP_WAIT, 1_000_000, clk cycles after reset before the first command may be issued
CLK_DIV, 1, clk cycles per flash_clk half-period (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only in IDLE
start_address  input  24  flash byte address of first word; sampled with start
word_count  input  24  number of 32-bit words to read; sampled with start
busy  output  1  high in every state except IDLE
word_data  output  32  assembled word; first flash byte in [7:0], fourth in [31:24]
word_valid  output  1  word_data valid; held until word_ready
word_ready  input  1  consumer accepts word when word_valid && word_ready
done  output  1  one-cycle pulse when the transfer completes
flash_clk  output  1  SPI clock, idle low
flash_mosi  output  1  SPI data to flash
flash_miso  input  1  SPI data from flash
flash_cs  output  1  SPI chip select, active-low

Behaviour:
- Reset values: busy=1, word_valid=0, word_data=0, done=0, flash_clk=0, flash_mosi=0, flash_cs=1; state POWER_UP, wait counter 0.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously); the transfer is abandoned; POWER_UP wait restarts.
- POWER_UP: count STARTUP_WAIT cycles, then IDLE (busy=0).
- IDLE: start=1 latches start_address and word_count. If word_count==0: done=1 on the next cycle, flash_cs stays 1, remain in IDLE. Otherwise go to SEND with flash_cs=0 and the shift register = {8'h03, start_address}. start outside IDLE is ignored.
- SEND: 32 bits, MSB first. Each bit is a low phase (flash_clk=0, mosi updated) followed by a high phase (flash_clk=1); each phase lasts CLK_DIV cycles. After the 32nd high phase, go to READ.
- READ: flash_clk toggles with the same phase timing. flash_miso is sampled at the end of each high phase. Each byte is assembled MSB first. Bytes fill word_data little-endian: byte 0 to [7:0] ... byte 3 to [31:24]. After the 32nd sampled bit, go to WAIT_READY with word_valid=1 and flash_clk=0.
- WAIT_READY: flash_clk held low and flash_cs held low for any stall length; word_data stays stable.
  - On valid&&ready: word_valid=0 on the next cycle and the remaining count decrements.
  - If the remaining count is nonzero: go to READ. The flash continues sequentially; no new command is sent.
  - If the remaining count is zero: go to FINISH.
- FINISH: flash_cs=1, flash_clk=0, done=1 for exactly one cycle, then IDLE.
- word_ready with word_valid=0 has no effect. word_valid never drops without a handshake, except on reset.
- Latency, start to first word_valid=1: 1 + 128*CLK_DIV cycles, with a tolerance of +3.
- Within a word, next word_valid follows the previous handshake by 64*CLK_DIV cycles, with a tolerance of +2.
- Address arithmetic is the flash's responsibility. Reads crossing 0xFFFFFF wrap inside the flash; the block does not check for this.
- Counter widths: the wait counter holds STARTUP_WAIT; the word counter is 24 bits; the bit counter is 6 bits.

Test Plan:
- Power-up: STARTUP_WAIT=20. busy=1 for cycles 0-19 after reset release, then 0; start pulsed at cycle 5 -> ignored, flash_cs stays 1.
- Command capture: start, start_address=0x000004, word_count=1. The flash model records mosi on rising flash_clk edges = 0x03,0x00,0x00,0x04. Model bytes at 0x4 are 37 55 00 00 -> word_data=0x00005537, then done pulse, flash_cs=1.
- Multi-word with backpressure: word_count=3 from 0x0, model bytes 00..0B. word_ready held low 50 cycles on word 2 -> flash_clk static low, cs low. Words = 0x03020100, 0x07060504, 0x0B0A0908; exactly 3 handshakes, 1 done.
- Zero count: word_count=0 -> done one cycle later, flash_cs never low, word_valid never high.
- CLK_DIV=3: flash_clk high/low phases each exactly 3 clk; first word_valid within 385-388 cycles of start.
- Reset mid-READ: rst_n low during byte 2 -> flash_cs=1, flash_clk=0, word_valid=0 in the same cycle. After the re-wait, a new start returns correct data.

Source files
------------

// File: rtl/flash_word_reader_if.sv
// rtl/flash_word_reader_if.sv - consumer handshake and SPI flash pins of the word reader
interface flash_word_reader_if;
  logic        start;
  logic [23:0] start_address;
  logic [23:0] word_count;
  logic        busy;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        done;
  logic        flash_clk;
  logic        flash_mosi;
  logic        flash_miso;
  logic        flash_cs;

  modport master (
    input  start, start_address, word_count, word_ready, flash_miso,
    output busy, word_data, word_valid, done, flash_clk, flash_mosi, flash_cs
  );

  modport slave (
    output start, start_address, word_count, word_ready, flash_miso,
    input  busy, word_data, word_valid, done, flash_clk, flash_mosi, flash_cs
  );
endinterface

// File: rtl/flash_word_reader.sv
// rtl/flash_word_reader.sv - SPI mode-0 flash read engine streaming 32-bit little-endian words
module flash_word_reader #(
  parameter int STARTUP_WAIT = 1_000_000,
  parameter int CLK_DIV      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  flash_word_reader_if.master bus
);
  localparam int WAIT_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT + 1) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {POWER_UP, IDLE, SEND, READ, WAIT_READY, FINISH} state_t;

  state_t             state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [DIV_W-1:0]   div_q;
  logic [5:0]         bit_q;
  logic [23:0]        cnt_q;
  logic [31:0]        shift_q;
  logic [31:0]        word_q;
  logic               valid_q;
  logic               done_q;
  logic               busy_q;
  logic               sclk_q;
  logic               cs_q;

  // mosi is the top of the command shifter; it drains to zero after the 32nd bit
  assign bus.flash_mosi = shift_q[31];
  assign bus.flash_clk  = sclk_q;
  assign bus.flash_cs   = cs_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_valid = valid_q;
  assign bus.word_data  = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POWER_UP;
      wait_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        POWER_UP: begin
          if (int'(wait_q) >= STARTUP_WAIT - 1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        IDLE: begin
          if (bus.start) begin
            if (bus.word_count == 24'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SEND;
              busy_q  <= 1'b1;
              cs_q    <= 1'b0;
              cnt_q   <= bus.word_count;
              shift_q <= {8'h03, bus.start_address};
              div_q   <= '0;
              bit_q   <= '0;
            end
          end
        end
        SEND: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q  <= 1'b0;
              shift_q <= {shift_q[30:0], 1'b0};
              if (bit_q == 6'd31) begin
                state_q <= READ;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 6'd1;
              end
            end
          end
        end
        READ: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // MSB-first within each byte, bytes placed little-endian
              sclk_q <= 1'b0;
              word_q[{bit_q[4:3], ~bit_q[2:0]}] <= bus.flash_miso;
              if (bit_q == 6'd31) begin
                state_q <= WAIT_READY;
                valid_q <= 1'b1;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 6'd1;
              end
            end
          end
        end
        WAIT_READY: begin
          if (bus.word_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q - 24'd1;
            div_q   <= '0;
            if (cnt_q == 24'd1) begin
              state_q <= FINISH;
              cs_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_word_reader.sv
// tb/tb_flash_word_reader.sv - scoreboard bench for flash_word_reader with a behavioural SPI flash
module tb_flash_word_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  flash_word_reader_if b1 ();
  flash_word_reader_if b3 ();

  flash_word_reader #(.STARTUP_WAIT(20), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1.master));
  flash_word_reader #(.STARTUP_WAIT(20), .CLK_DIV(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3.master));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // flash model: index 0 serves dut1, index 1 serves dut3
  logic [7:0]  mem [16];
  logic [1:0]  fclk, fcs, fmosi, pclk;
  logic [1:0]  fmiso = 2'b00;
  int          rise [2] = '{0, 0};
  int          idx  [2] = '{0, 0};
  logic [31:0] cmd  [2] = '{32'h0, 32'h0};
  logic [3:0]  addr4;
  logic [7:0]  byte_v;

  assign fclk  = {b3.flash_clk, b1.flash_clk};
  assign fcs   = {b3.flash_cs, b1.flash_cs};
  assign fmosi = {b3.flash_mosi, b1.flash_mosi};
  assign b1.flash_miso = fmiso[0];
  assign b3.flash_miso = fmiso[1];

  initial pclk = 2'b00;
  always @(fclk or fcs) begin
    for (int g = 0; g < 2; g++) begin
      if (fcs[g]) begin
        rise[g] = 0;
        idx[g]  = 0;
      end else if (fclk[g] && !pclk[g]) begin
        if (rise[g] < 32) cmd[g] = {cmd[g][30:0], fmosi[g]};
        rise[g]++;
      end else if (!fclk[g] && pclk[g] && rise[g] >= 32) begin
        addr4    = cmd[g][3:0] + 4'(idx[g] / 8);
        byte_v   = mem[addr4];
        fmiso[g] = byte_v[3'd7 - 3'(idx[g] % 8)];
        idx[g]++;
      end
      pclk[g] = fclk[g];
    end
  end

  // scoreboards and monitors
  logic [31:0] exp1 [$];
  logic [31:0] exp3 [$];
  int hs1 = 0, hs3 = 0, done1 = 0, done3 = 0;
  logic cs_low1 = 1'b0, valid_hi1 = 1'b0;
  int run3 = 0, hi_runs3 = 0, phase_bad3 = 0;
  logic prev3 = 1'b0;

  always @(negedge clk) begin
    if (b1.word_valid && b1.word_ready) begin
      hs1++;
      if (exp1.size() == 0) begin
        tot_cnt++;
        $display("FAIL word1_unexpected: got %h expected none", b1.word_data);
      end else check("word1", b1.word_data, exp1.pop_front());
    end
    if (b1.done) done1++;
    if (!b1.flash_cs) cs_low1 = 1'b1;
    if (b1.word_valid) valid_hi1 = 1'b1;
  end

  always @(negedge clk) begin
    if (b3.word_valid && b3.word_ready) begin
      hs3++;
      if (exp3.size() == 0) begin
        tot_cnt++;
        $display("FAIL word3_unexpected: got %h expected none", b3.word_data);
      end else check("word3", b3.word_data, exp3.pop_front());
    end
    if (b3.done) done3++;
    if (b3.flash_cs) begin
      run3  = 0;
      prev3 = 1'b0;
    end else if (b3.flash_clk == prev3) begin
      run3++;
    end else begin
      if (prev3) begin
        hi_runs3++;
        if (run3 != 3) phase_bad3++;
      end else if (rise[1] <= 32 && run3 != 3) begin
        phase_bad3++;
      end
      run3  = 1;
      prev3 = b3.flash_clk;
    end
  end

  task automatic run1(input logic [23:0] a, input logic [23:0] n);
    b1.start = 1'b1; b1.start_address = a; b1.word_count = n;
    @(posedge clk); #1;
    b1.start = 1'b0;
  endtask

  task automatic wait_done1(input string name);
    int d0, k;
    d0 = done1; k = 0;
    while (done1 == d0 && k < 3000) begin @(posedge clk); #1; k++; end
    check({name, "_done_seen"}, 32'(done1 != d0), 32'd1);
  endtask

  initial begin
    int h0, d0, n, stall_bad;
    logic [31:0] snap;
    b1.start = 0; b1.start_address = 0; b1.word_count = 0; b1.word_ready = 1;
    b3.start = 0; b3.start_address = 0; b3.word_count = 0; b3.word_ready = 1;
    rst1_n = 0; rst3_n = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", b1.busy, 1);
    check("rst_valid", b1.word_valid, 0);
    check("rst_data", b1.word_data, 0);
    check("rst_done", b1.done, 0);
    check("rst_fclk", b1.flash_clk, 0);
    check("rst_mosi", b1.flash_mosi, 0);
    check("rst_cs", b1.flash_cs, 1);
    cs_low1 = 0;
    rst1_n = 1; rst3_n = 1;

    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 5) b1.start = 1'b1;
      if (c == 6) b1.start = 1'b0;
      if (c == 19) check("pwr_busy_c19", b1.busy, 1);
      if (c == 20) check("pwr_busy_c20", b1.busy, 0);
    end
    check("pwr_start_ignored_cs", cs_low1, 0);
    check("pwr_start_ignored_done", done1, 0);

    mem[4] = 8'h37; mem[5] = 8'h55; mem[6] = 8'h00; mem[7] = 8'h00;
    exp1.push_back(32'h00005537);
    run1(24'h000004, 24'd1);
    wait_done1("single");
    check("cmd_bits", cmd[0], 32'h03000004);
    check("single_done_one_cycle", b1.done, 0);
    check("single_cs_high", b1.flash_cs, 1);
    check("single_idle", b1.busy, 0);

    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    exp1.push_back(32'h03020100); exp1.push_back(32'h07060504); exp1.push_back(32'h0B0A0908);
    h0 = hs1; d0 = done1;
    run1(24'h000000, 24'd3);
    n = 0;
    while (hs1 == h0 && n < 500) begin @(posedge clk); #1; n++; end
    b1.word_ready = 1'b0;
    n = 0;
    while (!b1.word_valid && n < 500) begin @(posedge clk); #1; n++; end
    check("stall_valid_seen", b1.word_valid, 1);
    snap = b1.word_data; stall_bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (b1.flash_clk !== 1'b0 || b1.flash_cs !== 1'b0 || b1.word_valid !== 1'b1 || b1.word_data !== snap)
        stall_bad++;
    end
    check("stall_static", stall_bad, 0);
    b1.word_ready = 1'b1;
    wait_done1("multi");
    check("multi_handshakes", hs1 - h0, 3);
    check("multi_dones", done1 - d0, 1);

    cs_low1 = 0; valid_hi1 = 0; d0 = done1;
    run1(24'h000010, 24'd0);
    check("zero_done_next", b1.done, 1);
    @(posedge clk); #1;
    check("zero_done_clear", b1.done, 0);
    repeat (5) @(posedge clk);
    #1;
    check("zero_cs_never_low", cs_low1, 0);
    check("zero_valid_never", valid_hi1, 0);
    check("zero_done_count", done1 - d0, 1);

    exp3.push_back(32'h0B0A0908);
    hi_runs3 = 0; phase_bad3 = 0;
    b3.start = 1'b1; b3.start_address = 24'h000008; b3.word_count = 24'd1;
    n = 0;
    while (!b3.word_valid && n < 1000) begin
      @(posedge clk); #1; n++;
      if (n == 1) b3.start = 1'b0;
    end
    check("div3_latency", 32'(n >= 385 && n <= 388), 1);
    n = 0;
    while (done3 == 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("div3_done", done3, 1);
    check("div3_high_phases", hi_runs3, 64);
    check("div3_phase_len", phase_bad3, 0);

    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    exp1.push_back(32'hA3A2A1A0);
    run1(24'h000000, 24'd1);
    n = 0;
    while (idx[0] < 18 && n < 500) begin @(posedge clk); #1; n++; end
    check("rst_mid_reached_byte2", 32'(idx[0] >= 18), 1);
    rst1_n = 1'b0;
    #1;
    check("rst_mid_cs", b1.flash_cs, 1);
    check("rst_mid_fclk", b1.flash_clk, 0);
    check("rst_mid_valid", b1.word_valid, 0);
    check("rst_mid_busy", b1.busy, 1);
    exp1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst1_n = 1'b1;
    n = 0;
    while (b1.busy && n < 100) begin @(posedge clk); #1; n++; end
    check("rewait_len", n, 20);
    exp1.push_back(32'hA7A6A5A4);
    run1(24'h000004, 24'd1);
    wait_done1("after_reset");
    check("queue_empty", exp1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
